arm_load_store_unit: RTL and testbench

Memory-access initiator that drives the core's word-wide data memory port: combinational read, single-cycle synchronous write, word index = address[31:2]. It accepts byte, halfword and word load/store requests from the execute stage over a valid/ready handshake. It performs sub-word extraction with sign/zero extension, read-modify-write for sub-word stores, and alignment checking. It returns one response per request over a valid/ready handshake.

---
 rtl/arm_lsu_pkg.sv | 23 ++
 rtl/arm_lsu_lane_align.sv | 54 +++++
 rtl/arm_load_store_unit.sv | 129 ++++++++++++
 tb/tb_arm_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_lsu_pkg.sv
// Shared types and constants for the ARM load/store unit.
//   access_size_t : encoding of the request size field
//   lsu_state_t   : control FSM states
//   LANES         : byte lanes in one memory word
package arm_lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/arm_lsu_lane_align.sv
// Combinational byte-lane steering for a little-endian 32-bit word.
//   i_Word        : word read from memory
//   i_Size        : access size (access_size_t encoding)
//   i_Lane        : byte offset within the word (addr[1:0])
//   i_Signed      : sign-extend sub-word loads when set
//   i_Store_Data  : right-aligned store data
//   o_Load_Data   : selected lane, extended to 32 bits
//   o_Merged_Word : i_Word with the store data inserted at the lane
// Halfword accesses use i_Lane[1] only, so addr[0] is ignored here.
module arm_lsu_lane_align
  import arm_lsu_pkg::*;
(
  input  logic [31:0] i_Word,
  input  logic [1:0]  i_Size,
  input  logic [1:0]  i_Lane,
  input  logic        i_Signed,
  input  logic [31:0] i_Store_Data,
  output logic [31:0] o_Load_Data,
  output logic [31:0] o_Merged_Word
);

  access_size_t           size;
  logic [LANES-1:0][7:0]  word_bytes;
  logic [LANES-1:0][7:0]  merged_bytes;
  logic [7:0]             sel_byte;
  logic [15:0]            sel_half;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    size          = access_size_t'(i_Size);
    word_bytes    = i_Word;
    merged_bytes  = i_Word;
    sel_byte      = word_bytes[i_Lane];
    sel_half      = i_Lane[1] ? i_Word[31:16] : i_Word[15:0];
    o_Load_Data   = i_Word;
    o_Merged_Word = i_Store_Data;
    case (size)
      SIZE_BYTE: begin
        o_Load_Data          = {{24{i_Signed & sel_byte[7]}}, sel_byte};
        merged_bytes[i_Lane] = i_Store_Data[7:0];
        o_Merged_Word        = merged_bytes;
      end
      SIZE_HALF: begin
        o_Load_Data                     = {{16{i_Signed & sel_half[15]}}, sel_half};
        merged_bytes[{i_Lane[1], 1'b0}] = i_Store_Data[7:0];
        merged_bytes[{i_Lane[1], 1'b1}] = i_Store_Data[15:8];
        o_Merged_Word                   = merged_bytes;
      end
      default: ;  // word (and illegal, which never reaches memory) pass through
    endcase
  end

endmodule

// File: rtl/arm_load_store_unit.sv
// Load/store unit driving a word-wide data memory (combinational read,
// single-cycle synchronous write). Accepts byte/half/word requests over a
// valid/ready handshake and returns one response per request.
//   i_CLK, i_RESET_N        : clock, async active-low reset
//   i_Req_*, o_Req_Ready    : request channel from execute
//   o_Resp_*, i_Resp_Ready  : response channel (extended load data, fault)
//   o_Mem_*, i_Mem_Read_Data: memory port, word-aligned address
// Configuration macro ARM_LSU_ALIGN_FAULT_EN: when defined, misaligned and
// illegal-size requests fault without touching memory; when undefined there
// are no faults, low address bits are ignored and size 11 acts as word.
module arm_load_store_unit
  import arm_lsu_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                i_CLK,
  input  logic                i_RESET_N,
  input  logic                i_Req_Valid,
  output logic                o_Req_Ready,
  input  logic                i_Req_Write,
  input  logic [1:0]          i_Req_Size,
  input  logic                i_Req_Signed,
  input  logic [BusWidth-1:0] i_Req_Address,
  input  logic [BusWidth-1:0] i_Req_Write_Data,
  output logic                o_Resp_Valid,
  input  logic                i_Resp_Ready,
  output logic [BusWidth-1:0] o_Resp_Read_Data,
  output logic                o_Resp_Fault,
  output logic [BusWidth-1:0] o_Mem_Address,
  output logic                o_Mem_Write_Enable,
  output logic [BusWidth-1:0] o_Mem_Write_Data,
  input  logic [BusWidth-1:0] i_Mem_Read_Data
);

  lsu_state_t          state;
  logic                write_q;
  logic                signed_q;
  access_size_t        size_q;
  logic [BusWidth-1:0] addr_q;
  logic [BusWidth-1:0] wdata_q;
  logic [BusWidth-1:0] rdata_q;
  logic                fault_q;

  access_size_t        req_size;
  logic                req_fault;
  logic [BusWidth-1:0] load_data;
  logic [BusWidth-1:0] merged_word;

  // Size normalisation and fault decode for the request being offered.
  always_comb begin
    req_size  = access_size_t'(i_Req_Size);
    req_fault = 1'b0;
`ifdef ARM_LSU_ALIGN_FAULT_EN
    case (req_size)
      SIZE_HALF:    req_fault = i_Req_Address[0];
      SIZE_WORD:    req_fault = |i_Req_Address[1:0];
      SIZE_ILLEGAL: req_fault = 1'b1;
      default:      req_fault = 1'b0;
    endcase
`else
    // Without checking, fault_q stays 0 and o_Resp_Fault is constant 0.
    if (req_size == SIZE_ILLEGAL) req_size = SIZE_WORD;
`endif
  end

  arm_lsu_lane_align u_lane_align (
    .i_Word        (i_Mem_Read_Data),
    .i_Size        (size_q),
    .i_Lane        (addr_q[1:0]),
    .i_Signed      (signed_q),
    .i_Store_Data  (wdata_q),
    .o_Load_Data   (load_data),
    .o_Merged_Word (merged_word)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Req_Valid) begin
            write_q  <= i_Req_Write;
            signed_q <= i_Req_Signed;
            size_q   <= req_size;
            addr_q   <= i_Req_Address;
            wdata_q  <= i_Req_Write_Data;
            rdata_q  <= '0;
            fault_q  <= req_fault;
            if (req_fault)                                  state <= RESP;
            else if (i_Req_Write && req_size == SIZE_WORD)  state <= WRITE;
            else                                            state <= READ;
          end
        end
        READ: begin
          if (write_q) begin
            wdata_q <= merged_word;  // read-modify-write of a sub-word store
            state   <= WRITE;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP:  if (i_Resp_Ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and strobe are pure state decodes, so reset drops them at once.
  assign o_Req_Ready        = (state == IDLE);
  assign o_Resp_Valid       = (state == RESP);
  assign o_Mem_Write_Enable = (state == WRITE);
  assign o_Mem_Address      = {addr_q[BusWidth-1:2], 2'b00};
  assign o_Mem_Write_Data   = wdata_q;
  assign o_Resp_Read_Data   = rdata_q;
  assign o_Resp_Fault       = fault_q;

endmodule

// File: tb/tb_arm_load_store_unit.sv
// Directed self-checking bench for arm_load_store_unit with a 16-word RAM.
module tb_arm_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we)     ram[mem_addr[5:2]] <= mem_wdata;
    else if (pl_en) ram[pl_idx] <= pl_data;
  end

  arm_load_store_unit dut (
    .i_CLK              (clk),
    .i_RESET_N          (rst_n),
    .i_Req_Valid        (req_valid),
    .o_Req_Ready        (req_ready),
    .i_Req_Write        (req_write),
    .i_Req_Size         (req_size),
    .i_Req_Signed       (req_signed),
    .i_Req_Address      (req_addr),
    .i_Req_Write_Data   (req_wdata),
    .o_Resp_Valid       (resp_valid),
    .i_Resp_Ready       (resp_ready),
    .o_Resp_Read_Data   (resp_rdata),
    .o_Resp_Fault       (resp_fault),
    .o_Mem_Address      (mem_addr),
    .o_Mem_Write_Enable (mem_we),
    .o_Mem_Write_Data   (mem_wdata),
    .i_Mem_Read_Data    (mem_rdata)
  );

  // ---------------- stimulus helpers (called at #1 after a rising edge) ----
  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_write = w; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Presents a request for one edge (the accept edge, cycle 0).
  task automatic issue(input logic w, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    set_req(w, size, sgn, addr, wdata);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Starts in cycle 1; returns the cycle of first o_Resp_Valid (0 on timeout)
  // and a bitmap of the cycles in which the write strobe was high.
  task automatic wait_resp(output int lat, output logic [15:0] we_mask);
    lat = 0;
    we_mask = '0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (mem_we) we_mask[c] = 1'b1;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic respond();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset_values(input string name);
    tests_run++;
    if ({resp_valid, mem_we, resp_fault, req_ready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL %s flags{valid,we,fault,ready}: got %b expected 0001", name,
               {resp_valid, mem_we, resp_fault, req_ready});
    end
    tests_run++;
    if (mem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL %s mem_addr: got %h expected 0", name, mem_addr);
    end
    tests_run++;
    if (mem_wdata !== 32'h0) begin
      tests_failed++; $display("FAIL %s mem_wdata: got %h expected 0", name, mem_wdata);
    end
    tests_run++;
    if (resp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL %s resp_rdata: got %h expected 0", name, resp_rdata);
    end
  endtask

  task automatic test_reset();
    #12;
    test_reset_values("reset_during");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset_values("reset_after");
  endtask

  // One full transaction with latency, strobe pattern and response checks.
  task automatic test_access(input string name, input logic w, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_lat, input logic [31:0] exp_data,
                             input logic exp_fault, input logic [15:0] exp_mask);
    int          lat;
    logic [15:0] mask;
    issue(w, size, sgn, addr, wdata);
    wait_resp(lat, mask);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (mask !== exp_mask) begin
      tests_failed++; $display("FAIL %s write_strobe_cycles: got %h expected %h", name, mask, exp_mask);
    end
    tests_run++;
    if ({resp_fault, resp_rdata} !== {exp_fault, exp_data}) begin
      tests_failed++;
      $display("FAIL %s fault/data: got %b/%h expected %b/%h", name, resp_fault, resp_rdata,
               exp_fault, exp_data);
    end
    tests_run++;
    if (mem_addr !== {addr[31:2], 2'b00}) begin
      tests_failed++;
      $display("FAIL %s mem_addr: got %h expected %h", name, mem_addr, {addr[31:2], 2'b00});
    end
    respond();
  endtask

  task automatic check_ram(input string name, input int idx, input logic [31:0] exp);
    tests_run++;
    if (ram[idx] !== exp) begin
      tests_failed++; $display("FAIL %s ram[%0d]: got %h expected %h", name, idx, ram[idx], exp);
    end
  endtask

  task automatic test_loads();
    preload(4'd1, 32'h8899AABB);
    test_access("load_word_0x4",  1'b0, 2'b10, 1'b0, 32'h4, '0, 2, 32'h8899AABB, 1'b0, 16'h0);
    test_access("load_sbyte_0x7", 1'b0, 2'b00, 1'b1, 32'h7, '0, 2, 32'hFFFFFF88, 1'b0, 16'h0);
    test_access("load_uhalf_0x6", 1'b0, 2'b01, 1'b0, 32'h6, '0, 2, 32'h00008899, 1'b0, 16'h0);
    test_access("load_shalf_0x6", 1'b0, 2'b01, 1'b1, 32'h6, '0, 2, 32'hFFFF8899, 1'b0, 16'h0);
    test_access("load_ubyte_0x4", 1'b0, 2'b00, 1'b0, 32'h4, '0, 2, 32'h000000BB, 1'b0, 16'h0);
    test_access("load_sbyte_0x5", 1'b0, 2'b00, 1'b1, 32'h5, '0, 2, 32'hFFFFFFAA, 1'b0, 16'h0);
    test_access("load_shalf_0x4", 1'b0, 2'b01, 1'b1, 32'h4, '0, 2, 32'hFFFFAABB, 1'b0, 16'h0);
  endtask

  task automatic test_stores();
    preload(4'd1, 32'h8899AABB);
    test_access("store_half_0x6", 1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, 3, 32'h0, 1'b0, 16'h0004);
    check_ram("store_half_0x6", 1, 32'h1234AABB);
    test_access("store_byte_0x5", 1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFCD, 3, 32'h0, 1'b0, 16'h0004);
    check_ram("store_byte_0x5", 1, 32'h1234CDBB);
    preload(4'd2, 32'h01020304);
    test_access("store_word_0x8", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0, 16'h0002);
    check_ram("store_word_0x8", 2, 32'hDEADBEEF);
  endtask

  task automatic test_alignment();
    preload(4'd1, 32'h8899AABB);
`ifdef ARM_LSU_ALIGN_FAULT_EN
    test_access("fault_word_0x5",   1'b0, 2'b10, 1'b0, 32'h5, '0, 1, 32'h0, 1'b1, 16'h0);
    test_access("fault_size11",     1'b0, 2'b11, 1'b0, 32'h4, '0, 1, 32'h0, 1'b1, 16'h0);
    test_access("fault_half_store", 1'b1, 2'b01, 1'b0, 32'h5, 32'h5678, 1, 32'h0, 1'b1, 16'h0);
    check_ram("fault_half_store", 1, 32'h8899AABB);
`else
    test_access("noalign_word_0x5",   1'b0, 2'b10, 1'b0, 32'h5, '0, 2, 32'h8899AABB, 1'b0, 16'h0);
    test_access("noalign_size11",     1'b0, 2'b11, 1'b0, 32'h4, '0, 2, 32'h8899AABB, 1'b0, 16'h0);
    test_access("noalign_half_store", 1'b1, 2'b01, 1'b0, 32'h5, 32'h5678, 3, 32'h0, 1'b0, 16'h0004);
    check_ram("noalign_half_store", 1, 32'h88995678);
`endif
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [15:0] mask;
    preload(4'd1, 32'h8899AABB);
    preload(4'd3, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, '0);
    wait_resp(lat, mask);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL backpressure latency: got %0d expected 2", lat);
    end
    // Offer a word store while the response is stalled; it must be ignored.
    set_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({resp_valid, req_ready, mem_we, resp_rdata} !== {3'b100, 32'h8899AABB}) begin
        tests_failed++;
        $display("FAIL backpressure hold%0d {valid,ready,we,data}: got %b%b%b/%h expected 100/8899aabb",
                 i, resp_valid, req_ready, mem_we, resp_rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL backpressure after_handshake {valid,ready}: got %b expected 01", {resp_valid, req_ready});
    end
    @(posedge clk); #1;  // queued store accepted on this edge
    req_valid = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure queued_accept ready: got %b expected 0", req_ready);
    end
    wait_resp(lat, mask);
    tests_run++;
    if ({lat[3:0], mask} !== {4'd2, 16'h0002}) begin
      tests_failed++;
      $display("FAIL backpressure queued_store latency/strobe: got %0d/%h expected 2/0002", lat, mask);
    end
    respond();
    check_ram("backpressure queued_store", 3, 32'hCAFEF00D);
  endtask

  task automatic test_reset_mid_write();
    preload(4'd3, 32'h11111111);
    issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h22222222);
    tests_run++;
    if (mem_we !== 1'b1) begin
      tests_failed++; $display("FAIL mid_write strobe_before_reset: got %b expected 1", mem_we);
    end
    #1 rst_n = 1'b0;
    #1;
    test_reset_values("mid_write_reset");
    @(posedge clk); #1;
    check_ram("mid_write_reset", 3, 32'h11111111);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_access("post_reset_load", 1'b0, 2'b10, 1'b0, 32'hC, '0, 2, 32'h11111111, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_alignment();
    test_backpressure();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
